// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN spike-rate readout stage.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_NONE = 2'b00;
    localparam logic [1:0] CLS_N1   = 2'b01;
    localparam logic [1:0] CLS_N2   = 2'b10;

    localparam int CNT_W_DEF = 5;

endpackage

// File: rtl/spike_counter.sv
// Per-channel saturating spike counter for one observation window.
// With SPIKE_DECODER_TTFS_EN defined it also latches the window index of
// the first counted spike (time-to-first-spike).
// count_next is the value including the current sample, so the parent can
// register a final result on the last window edge without an extra cycle.
module spike_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef SPIKE_DECODER_TTFS_EN
    ,
    parameter int TS_W  = 4
`endif
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             spike,
`ifdef SPIKE_DECODER_TTFS_EN
    input  logic [TS_W-1:0]  index,
    output logic [TS_W-1:0]  first_ts_next,
`endif
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;

    // next count: increment on a counted spike, hold at the maximum
    always_comb begin
        count_next = count;
        if (enable && spike && (count != CNT_MAX)) begin
            count_next = count + 1'b1;
        end
    end

    // count register, cleared at window start
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

`ifdef SPIKE_DECODER_TTFS_EN
    logic [TS_W-1:0] first_ts;

    // a zero count means no spike has been counted yet in this window
    always_comb begin
        first_ts_next = first_ts;
        if (enable && spike && (count == '0)) begin
            first_ts_next = index;
        end
    end

    // first-spike timestamp register, cleared at window start
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            first_ts <= '0;
        end else if (clear) begin
            first_ts <= '0;
        end else begin
            first_ts <= first_ts_next;
        end
    end
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate readout: counts spikes on two output-neuron channels over a
// WINDOW-cycle observation window, then presents a class decision and both
// counts through a valid/ready handshake.
// Optional macro SPIKE_DECODER_TTFS_EN: equal nonzero counts are resolved by
// the earlier first spike.
//
// state | meaning
// IDLE  | waiting for start_i; last result retained on the outputs
// COUNT | sampling spikes, one window index per edge
// DONE  | result valid, held until ready_i
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int WINDOW = 16,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TS_W   = $clog2(WINDOW)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             spike1_i,
    input  logic             spike2_i,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [1:0]       class_o,
    output logic [CNT_W-1:0] count1_o,
    output logic [CNT_W-1:0] count2_o
);

    state_t           state, state_next;
    logic [TS_W-1:0]  idx;
    logic             clear, enable, last;
    logic [CNT_W-1:0] c1_next, c2_next;
    logic [1:0]       cls_next;

    assign last = (idx == TS_W'(WINDOW - 1));

    // state register
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic; start_i only matters in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_i) state_next = COUNT;
            COUNT:   if (last)    state_next = DONE;
            DONE:    if (ready_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state-decoded outputs and counter controls
    always_comb begin
        busy_o  = (state != IDLE);
        valid_o = (state == DONE);
        clear   = (state == IDLE) && start_i;
        enable  = (state == COUNT);
    end

    // window index, holds at WINDOW-1 on the final edge
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clear) begin
            idx <= '0;
        end else if (enable && !last) begin
            idx <= idx + 1'b1;
        end
    end

`ifdef SPIKE_DECODER_TTFS_EN
    logic [TS_W-1:0] ts1_next, ts2_next;
`endif

    spike_counter #(
        .CNT_W(CNT_W)
`ifdef SPIKE_DECODER_TTFS_EN
        ,
        .TS_W (TS_W)
`endif
    ) u_cnt1 (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .clear        (clear),
        .enable       (enable),
        .spike        (spike1_i),
`ifdef SPIKE_DECODER_TTFS_EN
        .index        (idx),
        .first_ts_next(ts1_next),
`endif
        .count_next   (c1_next)
    );

    spike_counter #(
        .CNT_W(CNT_W)
`ifdef SPIKE_DECODER_TTFS_EN
        ,
        .TS_W (TS_W)
`endif
    ) u_cnt2 (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .clear        (clear),
        .enable       (enable),
        .spike        (spike2_i),
`ifdef SPIKE_DECODER_TTFS_EN
        .index        (idx),
        .first_ts_next(ts2_next),
`endif
        .count_next   (c2_next)
    );

    // class decision from the counts including the final sample
    always_comb begin
        cls_next = CLS_NONE;
        if (c1_next > c2_next) begin
            cls_next = CLS_N1;
        end else if (c2_next > c1_next) begin
            cls_next = CLS_N2;
        end
`ifdef SPIKE_DECODER_TTFS_EN
        else if (c1_next != '0) begin
            if (ts1_next < ts2_next) begin
                cls_next = CLS_N1;
            end else if (ts2_next < ts1_next) begin
                cls_next = CLS_N2;
            end
        end
`endif
    end

    // result registers, loaded on the last window edge and held otherwise
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            class_o  <= CLS_NONE;
            count1_o <= '0;
            count2_o <= '0;
        end else if (enable && last) begin
            class_o  <= cls_next;
            count1_o <= c1_next;
            count2_o <= c2_next;
        end
    end

endmodule
